// File: rtl/victory_pkg.sv
// Shared types and default geometry for the end-of-game banner overlay.
package victory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLIDE = 2'd1,
        HOLD  = 2'd2
    } vstate_e;

    localparam int SPR_W_DEF      = 100;
    localparam int SPR_H_DEF      = 54;
    localparam int SCALE_DEF      = 2;
    localparam int POS_X_DEF      = 220;
    localparam int FINAL_Y_DEF    = 184;
    localparam int SLIDE_STEP_DEF = 4;

    localparam int COORD_W = 10;
    localparam int ADDR_W  = 19;

    localparam logic [23:0] KEY_COLOR = 24'h000000;

endpackage

// File: rtl/victory_addr_gen.sv
// Combinational banner hit test and sprite RAM address for the current pixel.
module victory_addr_gen
    import victory_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF,
    parameter int SCALE = SCALE_DEF,
    parameter int POS_X = POS_X_DEF
) (
    input  logic [COORD_W-1:0] draw_x_i,
    input  logic [COORD_W-1:0] draw_y_i,
    input  logic [COORD_W-1:0] banner_y_i,
    output logic               in_box_o,
    output logic [ADDR_W-1:0]  addr_o
);

    localparam logic [COORD_W:0] X0   = (COORD_W+1)'(POS_X);
    localparam logic [COORD_W:0] XLIM = (COORD_W+1)'(SPR_W * SCALE);
    localparam logic [COORD_W:0] YLIM = (COORD_W+1)'(SPR_H * SCALE);

    logic [COORD_W:0]  dx, dy;
    logic [ADDR_W-1:0] row, col;

    // The extra top bit is the borrow: a pixel left of / above the banner
    // never aliases into the box.
    always_comb begin
        dx       = {1'b0, draw_x_i} - X0;
        dy       = {1'b0, draw_y_i} - {1'b0, banner_y_i};
        in_box_o = !dx[COORD_W] && !dy[COORD_W] && (dx < XLIM) && (dy < YLIM);
        row      = ADDR_W'(dy[COORD_W-1:0]) / ADDR_W'(SCALE);
        col      = ADDR_W'(dx[COORD_W-1:0]) / ADDR_W'(SCALE);
        addr_o   = in_box_o ? (row * ADDR_W'(SPR_W) + col) : '0;
    end

endmodule

// File: rtl/victory_overlay.sv
// Victory banner: slides in from the top on game_over, then holds.
// Define VICTORY_OVERLAY_BLINK_EN to blink the held banner (32 frames on / 32 off).
module victory_overlay
    import victory_pkg::*;
#(
    parameter int SPR_W      = SPR_W_DEF,
    parameter int SPR_H      = SPR_H_DEF,
    parameter int SCALE      = SCALE_DEF,   // 1 or 2 only
    parameter int POS_X      = POS_X_DEF,
    parameter int FINAL_Y    = FINAL_Y_DEF,
    parameter int SLIDE_STEP = SLIDE_STEP_DEF
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               game_over,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [23:0]        bg_rgb,
    input  logic [23:0]        data_Out_vict,
    output logic [ADDR_W-1:0]  read_address,
    output logic [23:0]        pixel_rgb,
    output logic               banner_active
);

    localparam logic [COORD_W:0] FINAL = (COORD_W+1)'(FINAL_Y);
    localparam logic [COORD_W:0] STEP  = (COORD_W+1)'(SLIDE_STEP);

    vstate_e            state_q, state_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W:0]   y_step;
    logic               run_q;
    logic [23:0]        bg_q;
    logic               inbox_q, vis_q;
    logic               in_box, vis;

    victory_addr_gen #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .SCALE (SCALE),
        .POS_X (POS_X)
    ) u_addr (
        .draw_x_i   (DrawX),
        .draw_y_i   (DrawY),
        .banner_y_i (y_q),
        .in_box_o   (in_box),
        .addr_o     (read_address)
    );

    // Holds the FSM for one edge after reset release so the release is clean.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        y_step  = {1'b0, y_q} + STEP;
        if (run_q) begin
            case (state_q)
                IDLE: begin
                    if (game_over) begin
                        state_d = SLIDE;
                        y_d     = '0;
                    end
                end
                SLIDE: begin
                    if (!game_over) begin
                        state_d = IDLE;
                    end else if (frame_tick) begin
                        if (y_step >= FINAL) begin
                            y_d     = FINAL[COORD_W-1:0];
                            state_d = HOLD;
                        end else begin
                            y_d = y_step[COORD_W-1:0];
                        end
                    end
                end
                HOLD: begin
                    if (!game_over) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef VICTORY_OVERLAY_BLINK_EN
    logic [5:0] blink_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            blink_q <= '0;
        else if (state_q == SLIDE && state_d == HOLD)
            blink_q <= '0;
        else if (state_q == HOLD && state_d == HOLD && frame_tick)
            blink_q <= blink_q + 6'd1;
    end

    always_comb vis = (state_q == SLIDE) || (state_q == HOLD && !blink_q[5]);
`else
    always_comb vis = (state_q != IDLE);
`endif

    // Stage 1 lines bg and flags up with the RAM read data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bg_q    <= '0;
            inbox_q <= 1'b0;
            vis_q   <= 1'b0;
        end else begin
            bg_q    <= bg_rgb;
            inbox_q <= in_box;
            vis_q   <= vis;
        end
    end

    assign pixel_rgb     = (inbox_q && vis_q && data_Out_vict != KEY_COLOR) ? data_Out_vict : bg_q;
    assign banner_active = (state_q != IDLE);

endmodule

// File: tb/tb_victory_overlay.sv
// Randomised scoreboard bench for victory_overlay against an arithmetic reference model.
module tb_victory_overlay;

    localparam int SW = 100, SH = 54, SC = 2, PX = 220, FY = 184, ST = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        game_over = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic [23:0] bg_rgb = '0;
    logic [23:0] data_Out_vict = '0;
    logic [18:0] read_address;
    logic [23:0] pixel_rgb;
    logic        banner_active;

    victory_overlay #(
        .SPR_W(SW), .SPR_H(SH), .SCALE(SC), .POS_X(PX), .FINAL_Y(FY), .SLIDE_STEP(ST)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .game_over     (game_over),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .bg_rgb        (bg_rgb),
        .data_Out_vict (data_Out_vict),
        .read_address  (read_address),
        .pixel_rgb     (pixel_rgb),
        .banner_active (banner_active)
    );

    always #5 Clk = ~Clk;

    int pass_cnt = 0, tot_cnt = 0;
    logic [23:0] exp_q[$];
    int ovr = -1;

    // Sprite RAM contents; every sixth address is transparent.
    function automatic logic [23:0] spr(input int a);
        logic [23:0] v;
        if (a % 6 == 1) return 24'h000000;
        v = 24'((a * 40503) ^ (a << 7)) | 24'h000001;
        return v;
    endfunction

    always @(posedge Clk) data_Out_vict <= (ovr >= 0) ? 24'(ovr) : spr(int'(read_address));

    // Reference model: 0 idle, 1 sliding, 2 holding.
    int mst = 0, my = 0, mcnt = 0, tick_total = 0;

    function automatic bit m_vis();
`ifdef VICTORY_OVERLAY_BLINK_EN
        return (mst == 1) || (mst == 2 && mcnt < 32);
`else
        return mst != 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    task automatic m_update(input bit go, input bit ft);
        case (mst)
            0: if (go) begin mst = 1; my = 0; end
            1: if (!go) mst = 0;
               else if (ft) begin
                   my = (my + ST > FY) ? FY : my + ST;
                   if (my == FY) begin mst = 2; mcnt = 0; end
               end
            default: if (!go) mst = 0;
                     else if (ft) mcnt = (mcnt + 1) % 64;
        endcase
    endtask

    task automatic step(input bit go, input bit ft, input int x, input int y, input int ov);
        int dx, dy, addr, d;
        bit inbox;
        logic [23:0] bg;
        @(negedge Clk);
        #1;
        bg = 24'($urandom);
        game_over = go; frame_tick = ft;
        DrawX = 10'(x); DrawY = 10'(y); bg_rgb = bg; ovr = ov;
        #1;
        dx = x - PX; dy = y - my;
        inbox = dx >= 0 && dx < SW * SC && dy >= 0 && dy < SH * SC;
        addr = inbox ? (dy / SC) * SW + dx / SC : 0;
        chk("read_address", int'(read_address), addr);
        d = (ov >= 0) ? ov : int'(spr(addr));
        exp_q.push_back((inbox && m_vis() && d != 0) ? 24'(d) : bg);
        @(posedge Clk);
        if (ft && go) tick_total++;
        m_update(go, ft);
        #1;
        chk("banner_active", int'(banner_active), int'(mst != 0));
    endtask

    function automatic int clampc(input int v);
        return v < 0 ? 0 : (v > 1023 ? 1023 : v);
    endfunction
    function automatic int near_x();
        return clampc(PX - 4 + int'($urandom_range(0, SW * SC + 8)));
    endfunction
    function automatic int near_y();
        return clampc(my - 4 + int'($urandom_range(0, SH * SC + 8)));
    endfunction

    // Monitor: one composited pixel per issued coordinate, one Clk later.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pixel_rgb", int'(pixel_rgb), int'(e));
            end
        end
    end

    initial begin
        int n;
        // Reset with arbitrary inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            game_over = 1'($urandom); frame_tick = 1'($urandom);
            DrawX = 10'($urandom); DrawY = 10'($urandom); bg_rgb = 24'($urandom);
            #2;
            chk("rst_pixel", int'(pixel_rgb), 0);
            chk("rst_active", int'(banner_active), 0);
        end
        @(negedge Clk);
        game_over = 1'b0; frame_tick = 1'b0;
        Reset_n = 1'b1;

        // Idle: background passes through
        for (int i = 0; i < 20; i++)
            step(0, 1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), -1);

        // Slide in over 46 ticks
        n = 0;
        while (mst != 2 && n < 400) begin
            step(1, (n % 3) == 2, near_x(), near_y(), -1);
            n++;
        end
        chk("hold_reached", int'(banner_active), 1);
        chk("ticks_to_hold", tick_total, 46);

        // Corners and keying in HOLD
        step(1, 0, 220, 184, -1);
        chk("addr_top_left", int'(read_address), 0);
        step(1, 0, 419, 291, -1);
        chk("addr_bot_right", int'(read_address), 5399);
        step(1, 0, 222, 186, -1);
        chk("addr_row1", int'(read_address), 101);
        step(1, 0, 420, 291, 24'hFF0000);
        chk("addr_out_right", int'(read_address), 0);
        step(1, 0, 230, 190, 0);
        step(1, 0, 230, 190, 24'hFF0000);

        // Hold long enough to see a full blink period
        for (int i = 0; i < 140; i++)
            step(1, (i % 2) == 1, near_x(), near_y(), -1);

        // Abort mid-slide with a coincident tick, then restart from the top
        step(0, 0, near_x(), near_y(), -1);
        for (int i = 0; i < 20; i++)
            step(1, (i % 2) == 1, near_x(), near_y(), -1);
        step(0, 1, near_x(), near_y(), -1);
        for (int i = 0; i < 3; i++)
            step(0, 1'($urandom), near_x(), near_y(), -1);
        step(1, 0, 220, 0, -1);
        step(1, 0, 220, 0, -1);
        chk("restart_y0", int'(read_address), 0);
        step(1, 0, 222, 2, -1);
        chk("restart_row1", int'(read_address), 101);
        for (int i = 0; i < 10; i++)
            step(1, (i % 2) == 1, near_x(), near_y(), -1);

        // Random tail
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 9) != 0), 1'($urandom), near_x(), near_y(), -1);

        @(negedge Clk);
        @(negedge Clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/victory_overlay.md
VICTORY_OVERLAY -- requirements
Module: victory_overlay

Interface
REQ-001 Parameter SPR_W, default 100, banner sprite width in sprite pixels.
REQ-002 Parameter SPR_H, default 54, banner sprite height in sprite pixels.
REQ-003 Parameter SCALE, default 2, integer screen-pixel magnification; only 1 or 2 are legal.
REQ-004 Parameter POS_X, default 220, screen column of banner left edge.
REQ-005 Parameter FINAL_Y, default 184, screen row of banner top edge when fully slid in.
REQ-006 Parameter SLIDE_STEP, default 4, rows moved per frame tick while sliding.
REQ-007 Clk  input  1  system clock; single clock domain.
REQ-008 Reset_n  input  1  reset; asynchronous, active-low.
REQ-009 frame_tick  input  1  one-Clk pulse at start of vertical blank.
REQ-010 game_over  input  1  level; high while the end-of-game screen is required.
REQ-011 DrawX, DrawY  input  10 each  current VGA pixel coordinates.
REQ-012 bg_rgb  input  24  background colour for (DrawX, DrawY), same cycle as the coordinates.
REQ-013 data_Out_vict  input  24  sprite RAM read data, valid one Clk after read_address.
REQ-014 read_address  output  19  sprite RAM read address.
REQ-015 pixel_rgb  output  24  composited colour, one Clk after the coordinates.
REQ-016 banner_active  output  1  high when the state is not IDLE.

Function
REQ-017 States: IDLE, SLIDE, HOLD; transitions are evaluated on every Clk.
REQ-018 IDLE->SLIDE when game_over=1; banner_y loads 0 on that transition.
REQ-019 In SLIDE, each frame_tick updates banner_y to min(banner_y+SLIDE_STEP, FINAL_Y); the state goes to HOLD on the tick that reaches FINAL_Y.
REQ-020 game_over=0 in any state forces IDLE on the next Clk, including mid-slide; this takes priority over a simultaneous frame_tick.
REQ-021 banner_y changes only on frame_tick, so the banner never tears within a frame.
REQ-022 In-box: 0 <= DrawX-POS_X < SPR_W*SCALE and 0 <= DrawY-banner_y < SPR_H*SCALE; the differences are unsigned with borrow, and a negative difference counts as out of box.
REQ-023 read_address = ((DrawY-banner_y)/SCALE)*SPR_W + (DrawX-POS_X)/SCALE when in box, 0 otherwise; combinational from the inputs.
REQ-024 Stage-1 registers capture bg_rgb, the in-box flag and the visibility flag each Clk.
REQ-025 pixel_rgb = data_Out_vict when the stage-1 in-box flag and the visibility flag are both 1 and data_Out_vict != 24'h000000; otherwise pixel_rgb = stage-1 bg_rgb.
REQ-026 Black (24'h000000) is the transparent key colour.
REQ-027 The visibility flag is 0 in IDLE and 1 in SLIDE and HOLD, except as modified by REQ-031.

Reset
REQ-028 On Reset_n low: state=IDLE, banner_y=0, stage-1 registers=0, blink counter=0; therefore pixel_rgb=0, banner_active=0, and read_address follows REQ-023.
REQ-029 Reset release is synchronous to Clk; the first state change happens on the second Clk edge after release.

Configuration
REQ-030 Macro VICTORY_OVERLAY_BLINK_EN selects the blink feature.
REQ-031 With the macro defined, a 6-bit counter in HOLD counts frame_tick and the visibility flag = NOT counter[5] (32 frames on, 32 off); the counter clears on entry to HOLD.
REQ-032 Without the macro, the counter is absent and the visibility flag is constantly 1 in HOLD.

Structure
REQ-033 Package victory_pkg holds the state enum, default geometry constants and the transparent key colour.
REQ-034 Sub-module victory_addr_gen holds the in-box test and address arithmetic of REQ-022/023, which are combinational.

Verification
REQ-035 Reset_n=0 with arbitrary inputs -> pixel_rgb=0 and banner_active=0; after release with game_over=0 -> pixel_rgb equals bg_rgb delayed one Clk.
REQ-036 game_over=1, then 46 frame_ticks -> banner_y = 4,8,...,184; HOLD is entered on tick 46; no overshoot.
REQ-037 HOLD, DrawX=220, DrawY=184 -> read_address=0; DrawX=419, DrawY=291 -> read_address=5399; DrawX=420 -> out of box, so pixel_rgb equals bg.
REQ-038 data_Out_vict=24'h000000 in box -> bg shown; 24'hFF0000 -> pixel_rgb=24'hFF0000 one Clk later.
REQ-039 game_over dropped on the same Clk as a frame_tick mid-SLIDE -> IDLE next Clk, and banner_y is reloaded to 0 on the next game_over.
REQ-040 VICTORY_OVERLAY_BLINK_EN defined, in HOLD -> banner visible for 32 frame_ticks, then hidden for 32, repeating.
